// File: rtl/parallel_to_serial.sv
// Transmit side of the byte serial link: captures a word on ready/load and shifts
// it out one bit per bit_tick, strobing shift_enable per bit and pulsing done at the end.
module parallel_to_serial #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             bit_tick,
    output logic             ready,
    output logic             busy,
    output logic             serial_out,
    output logic             shift_enable,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    count_q;
    logic             ready_q;
    logic             busy_q;
    logic             serialOut_q;
    logic             shiftEnable_q;
    logic             done_q;

    logic             nextBit_d;
    logic [WIDTH-1:0] shifted_d;

    // The bit leaving the register and the register after it has left, zero filled.
    assign nextBit_d = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shifted_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            serialOut_q   <= IDLE_LEVEL;
            shiftEnable_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q        <= 1'b0;
                    shiftEnable_q <= 1'b0;
                    serialOut_q   <= IDLE_LEVEL;
                    if (load) begin
                        shreg_q <= data_in;
                        count_q <= '0;
                        state_q <= SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        serialOut_q   <= nextBit_d;
                        shreg_q       <= shifted_d;
                        shiftEnable_q <= 1'b1;
                        // Hold the counter on the last bit so it never wraps.
                        if (count_q == LAST_COUNT) begin
                            state_q <= FINISH;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end else begin
                        shiftEnable_q <= 1'b0;
                    end
                end
                FINISH: begin
                    shiftEnable_q <= 1'b0;
                    serialOut_q   <= IDLE_LEVEL;
                    done_q        <= 1'b1;
                    ready_q       <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign serial_out   = serialOut_q;
    assign shift_enable = shiftEnable_q;
    assign done         = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: an MSB-first and an LSB-first instance,
// checked against a behavioural receiver model that rebuilds words from strobed bits.
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       rstN;
    logic       load, bitTick;
    logic [7:0] dataIn;
    logic       ready, busy, serialOut, shiftEnable, done;
    logic       loadB, tickB;
    logic [7:0] dataInB;
    logic       readyB, busyB, serialOutB, shiftEnableB, doneB;

    int errors = 0;
    int checks = 0;

    logic capBits[$];
    int   capStrobeK[$];
    int   capDoneK;
    int   capUnstable;
    int   capWait;
    logic capAcceptOk;

    parallel_to_serial #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dutMsb (
        .clk(clk), .rstN(rstN), .load(load), .data_in(dataIn), .bit_tick(bitTick),
        .ready(ready), .busy(busy), .serial_out(serialOut), .shift_enable(shiftEnable), .done(done)
    );

    parallel_to_serial #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dutLsb (
        .clk(clk), .rstN(rstN), .load(loadB), .data_in(dataInB), .bit_tick(tickB),
        .ready(readyB), .busy(busyB), .serial_out(serialOutB), .shift_enable(shiftEnableB), .done(doneB)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on the MSB-first instance with a tick every 'period' edges,
    // optionally pushing a rogue load after 'injectAt' bits, and records what the link carried.
    task automatic capture_frame(input logic [7:0] word, input int period,
                                 input int injectAt, input logic [7:0] injectWord);
        int   k;
        int   injectLeft;
        bit   injected;
        logic lastBit;
        capBits.delete();
        capStrobeK.delete();
        capDoneK    = -1;
        capUnstable = 0;
        capWait     = 0;
        injected    = 0;
        injectLeft  = 0;
        lastBit     = 1'b0;
        while (ready !== 1'b1 && capWait < 50) begin
            step();
            capWait++;
        end
        load    = 1'b1;
        dataIn  = word;
        bitTick = 1'($urandom_range(0, 1));
        step();
        capAcceptOk = (ready === 1'b0) && (busy === 1'b1);
        load   = 1'b0;
        dataIn = 8'($urandom);
        k = 0;
        while (k < 200) begin
            bitTick = ((k + 1) % period) == 0;
            if (injectAt >= 0 && !injected && capBits.size() == injectAt) begin
                injected   = 1;
                injectLeft = 3;
            end
            if (injectLeft > 0) begin
                load   = 1'b1;
                dataIn = injectWord;
                injectLeft--;
            end else begin
                load = 1'b0;
            end
            step();
            k++;
            if (shiftEnable === 1'b1) begin
                capBits.push_back(serialOut);
                capStrobeK.push_back(k);
                lastBit = serialOut;
            end else if (busy === 1'b1 && capBits.size() > 0 && serialOut !== lastBit) begin
                capUnstable++;
            end
            if (done === 1'b1) begin
                capDoneK = k;
                break;
            end
        end
        load    = 1'b0;
        bitTick = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; load = 1'b1; dataIn = 8'hA5; bitTick = 1'b1;
        loadB = 1'b0; dataInB = 8'h00; tickB = 1'b0;
        step();
        step();
        checks++; if (ready !== 1'b1)       begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (serialOut !== 1'b0)   begin errors++; $display("[TB] FAIL reset_serial: got %b expected 0", serialOut); end
        checks++; if (shiftEnable !== 1'b0) begin errors++; $display("[TB] FAIL reset_se: got %b expected 0", shiftEnable); end
        checks++; if (done !== 1'b0)        begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (readyB !== 1'b1)      begin errors++; $display("[TB] FAIL reset_readyB: got %b expected 1", readyB); end
        load = 1'b0; bitTick = 1'b0;
        rstN = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] expWord;
        expWord = 8'hA5;
        capture_frame(expWord, 1, -1, 8'h00);
        checks++; if (!capAcceptOk) begin errors++; $display("[TB] FAIL basic_accept: got ready=%b busy=%b expected ready=0 busy=1", ready, busy); end
        checks++; if (capBits.size() != 8) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 8", capBits.size()); end
        for (int i = 0; i < capBits.size() && i < 8; i++) begin
            checks++;
            if (capBits[i] !== 1'((expWord >> (7 - i)) & 8'd1)) begin
                errors++; $display("[TB] FAIL basic_bit%0d: got %b expected %b", i, capBits[i], (expWord >> (7 - i)) & 8'd1);
            end
            checks++;
            if (capStrobeK[i] != i + 1) begin
                errors++; $display("[TB] FAIL basic_strobe%0d: got cycle %0d expected %0d", i, capStrobeK[i], i + 1);
            end
        end
        checks++; if (capDoneK != 9) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 9", capDoneK); end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_at_done: got %b expected 1", ready); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_single: got %b expected 0", done); end
    endtask

    task automatic test_loopback();
        logic [7:0] words[4];
        logic [7:0] rx;
        words = '{8'h3C, 8'h00, 8'hFF, 8'h81};
        foreach (words[w]) begin
            capture_frame(words[w], 1, -1, 8'h00);
            rx = '0;
            foreach (capBits[i]) rx = (rx << 1) | 8'(capBits[i]);
            checks++; if (capBits.size() != 8 || rx !== words[w]) begin errors++; $display("[TB] FAIL loopback_%0h: got %0h (%0d bits) expected %0h", words[w], rx, capBits.size(), words[w]); end
            checks++; if (capDoneK != 9) begin errors++; $display("[TB] FAIL loopback_done_%0h: got %0d expected 9", words[w], capDoneK); end
        end
    endtask

    task automatic test_sparse_ticks();
        logic [7:0] rx;
        capture_frame(8'hC3, 3, -1, 8'h00);
        checks++; if (capBits.size() != 8) begin errors++; $display("[TB] FAIL sparse_count: got %0d expected 8", capBits.size()); end
        for (int i = 0; i < capStrobeK.size(); i++) begin
            checks++;
            if (capStrobeK[i] != 3 * (i + 1)) begin
                errors++; $display("[TB] FAIL sparse_strobe%0d: got cycle %0d expected %0d", i, capStrobeK[i], 3 * (i + 1));
            end
        end
        rx = '0;
        foreach (capBits[i]) rx = (rx << 1) | 8'(capBits[i]);
        checks++; if (rx !== 8'hC3) begin errors++; $display("[TB] FAIL sparse_word: got %0h expected c3", rx); end
        checks++; if (capUnstable != 0) begin errors++; $display("[TB] FAIL sparse_stable: got %0d changes expected 0", capUnstable); end
        checks++; if (capDoneK != 25) begin errors++; $display("[TB] FAIL sparse_done_cycle: got %0d expected 25", capDoneK); end
    endtask

    task automatic test_load_ignored();
        logic [7:0] rx;
        int strayBusy;
        capture_frame(8'h5A, 1, 3, 8'hFF);
        rx = '0;
        foreach (capBits[i]) rx = (rx << 1) | 8'(capBits[i]);
        checks++; if (capBits.size() != 8 || rx !== 8'h5A) begin errors++; $display("[TB] FAIL ignored_word: got %0h (%0d bits) expected 5a", rx, capBits.size()); end
        strayBusy = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0 || shiftEnable !== 1'b0) strayBusy++;
        end
        checks++; if (strayBusy != 0) begin errors++; $display("[TB] FAIL ignored_no_second_frame: got %0d busy cycles expected 0", strayBusy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx1, rx2;
        int n1;
        capture_frame(8'hF0, 1, -1, 8'h00);
        n1 = capBits.size();
        rx1 = '0;
        foreach (capBits[i]) rx1 = (rx1 << 1) | 8'(capBits[i]);
        capture_frame(8'h0F, 1, -1, 8'h00);
        rx2 = '0;
        foreach (capBits[i]) rx2 = (rx2 << 1) | 8'(capBits[i]);
        checks++; if (capWait != 0 || !capAcceptOk) begin errors++; $display("[TB] FAIL b2b_accept_in_done_cycle: got wait=%0d accept=%b expected 0/1", capWait, capAcceptOk); end
        checks++; if (n1 + capBits.size() != 16) begin errors++; $display("[TB] FAIL b2b_strobes: got %0d expected 16", n1 + capBits.size()); end
        checks++; if (rx1 !== 8'hF0 || rx2 !== 8'h0F) begin errors++; $display("[TB] FAIL b2b_words: got %0h,%0h expected f0,0f", rx1, rx2); end
    endtask

    task automatic test_reset_midframe();
        int strobes, doneSeen, seSeen;
        logic [7:0] rx;
        load = 1'b1; dataIn = 8'hAA; bitTick = 1'b1;
        step();
        load = 1'b0;
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (shiftEnable === 1'b1) strobes++;
        end
        checks++; if (strobes != 4) begin errors++; $display("[TB] FAIL midreset_prebits: got %0d expected 4", strobes); end
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready: got ready=%b busy=%b expected 1/0", ready, busy); end
        checks++; if (shiftEnable !== 1'b0 || serialOut !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got se=%b so=%b done=%b expected 0/0/0", shiftEnable, serialOut, done); end
        doneSeen = 0; seSeen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) doneSeen++;
            if (shiftEnable === 1'b1) seSeen++;
        end
        bitTick = 1'b0;
        checks++; if (doneSeen != 0 || seSeen != 0) begin errors++; $display("[TB] FAIL midreset_quiet: got done=%0d se=%0d expected 0/0", doneSeen, seSeen); end
        capture_frame(8'h55, 1, -1, 8'h00);
        rx = '0;
        foreach (capBits[i]) rx = (rx << 1) | 8'(capBits[i]);
        checks++; if (capBits.size() != 8 || rx !== 8'h55) begin errors++; $display("[TB] FAIL midreset_fresh: got %0h (%0d bits) expected 55", rx, capBits.size()); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic [7:0] rx;
        logic firstBit;
        int n, k;
        for (int f = 0; f < 4; f++) begin
            w = (f == 0) ? 8'h01 : 8'($urandom);
            loadB = 1'b1; dataInB = w; tickB = 1'b1;
            step();
            loadB = 1'b0;
            rx = '0; n = 0; k = 0; firstBit = 1'b0;
            while (k < 40 && doneB !== 1'b1) begin
                step();
                k++;
                if (shiftEnableB === 1'b1) begin
                    if (n == 0) firstBit = serialOutB;
                    if (n < 8) rx = rx | (8'(serialOutB) << n);
                    n++;
                end
            end
            tickB = 1'b0;
            checks++; if (n != 8 || rx !== w) begin errors++; $display("[TB] FAIL lsb_word_%0h: got %0h (%0d bits) expected %0h", w, rx, n, w); end
            checks++; if (firstBit !== w[0]) begin errors++; $display("[TB] FAIL lsb_first_bit_%0h: got %b expected %b", w, firstBit, w[0]); end
            step();
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        logic [7:0] rx;
        int period;
        for (int f = 0; f < 20; f++) begin
            w = 8'($urandom);
            period = $urandom_range(1, 4);
            capture_frame(w, period, -1, 8'h00);
            rx = '0;
            foreach (capBits[i]) rx = (rx << 1) | 8'(capBits[i]);
            checks++; if (capBits.size() != 8 || rx !== w) begin errors++; $display("[TB] FAIL rand_word_%0d: got %0h (%0d bits) expected %0h", f, rx, capBits.size(), w); end
            checks++; if (capDoneK != 8 * period + 1) begin errors++; $display("[TB] FAIL rand_done_%0d: got %0d expected %0d", f, capDoneK, 8 * period + 1); end
            checks++; if (capUnstable != 0) begin errors++; $display("[TB] FAIL rand_stable_%0d: got %0d expected 0", f, capUnstable); end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loopback();
        test_sparse_ticks();
        test_load_ignored();
        test_back_to_back();
        test_reset_midframe();
        test_lsb_first();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
